// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: drives the synchronous instruction memory and pairs each
// returned word with its PC, honouring decode stall, control-flow redirect and a halt opcode.
module instr_fetch_unit #(
    parameter int                ADDR_W    = 13,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
    parameter bit                HALT_EN   = 1'b1,
    parameter logic [DATA_W-1:0] HALT_WORD = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              valid_o,
    output logic              halted_o
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [ADDR_W-1:0] w_resp_pc_nxt;
    logic              r_resp_valid;
    logic              w_resp_valid_nxt;
    logic              w_halt_hit;

    assign valid_o  = r_resp_valid && (r_state == ST_RUN);
    assign pc_o     = r_resp_pc;
    assign instr_o  = imem_data_i;
    assign halted_o = (r_state == ST_HALTED);

    // Re-issuing the displayed PC during a stall keeps the memory output steady without a hold register.
    assign imem_addr_o = (stall_i && valid_o) ? r_resp_pc : r_fetch_pc;

    // The halt word only takes effect once decode actually accepts it.
    assign w_halt_hit = HALT_EN && valid_o && !stall_i && (imem_data_i == HALT_WORD);

    // Next-state and next-register selection: redirect > halt > stall > advance.
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_resp_pc_nxt    = r_resp_pc;
        w_resp_valid_nxt = r_resp_valid;
        if (redirect_i) begin
            w_state_nxt      = ST_RUN;
            w_fetch_pc_nxt   = redirect_addr_i;
            w_resp_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_halt_hit) begin
                        w_state_nxt      = ST_HALTED;
                        w_resp_valid_nxt = 1'b0;
                    end else if (!stall_i) begin
                        w_resp_pc_nxt    = r_fetch_pc;
                        w_resp_valid_nxt = 1'b1;
                        w_fetch_pc_nxt   = r_fetch_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else begin
                        w_resp_valid_nxt = r_resp_valid;
                    end
                end
                ST_HALTED: begin
                    w_state_nxt = ST_HALTED;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // State and fetch/response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_fetch_pc   <= RESET_PC;
            r_resp_pc    <= {ADDR_W{1'b0}};
            r_resp_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_resp_pc    <= w_resp_pc_nxt;
            r_resp_valid <= w_resp_valid_nxt;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch front end and sole read master of the synchronous instruction memory (13-bit word address, 32-bit word, data registered one clock after address). Generates the word address sequence, aligns each returned word with its PC, and presents instr/pc/valid to decode. Supports decode back-pressure (stall), control-flow redirect and a halt opcode. Sits between the instruction memory and the IF/ID boundary.

Parameters:
ADDR_W, 13, word-address width; matches instruction memory address port.
DATA_W, 32, instruction word width.
RESET_PC, 0, first word address fetched after reset.
HALT_EN, 1, 1 enables halt-word detection; 0 never enters HALTED.
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
clk  in  1  single clock, all state on rising edge.
rst  in  1  synchronous, active-high reset.
stall_i  in  1  decode cannot accept; freeze fetch.
redirect_i  in  1  load new PC (branch/jump/exception).
redirect_addr_i  in  ADDR_W  redirect target word address.
imem_addr_o  out  ADDR_W  address to instruction memory.
imem_data_i  in  DATA_W  memory read data, valid one cycle after address.
instr_o  out  DATA_W  instruction to decode (= imem_data_i, unregistered passthrough).
pc_o  out  ADDR_W  word address of instr_o.
valid_o  out  1  instr_o/pc_o are a live instruction.
halted_o  out  1  fetch stopped on HALT_WORD.

Behaviour:
- Registers: fetch_pc (next address to issue), resp_pc, resp_valid, state {RUN, HALTED}.
- Reset (rst=1 at edge): fetch_pc<=RESET_PC, resp_pc<=0, resp_valid<=0, state<=RUN. Outputs in cycle after reset: imem_addr_o=RESET_PC, valid_o=0, pc_o=0, halted_o=0. First valid instruction (mem[RESET_PC]) appears the following cycle. rst overrides every other input, including mid-stall, mid-redirect and in HALTED.
- imem_addr_o = resp_pc when (stall_i && resp_valid && state==RUN), else fetch_pc. Replaying resp_pc keeps imem_data_i stable across a stall; no hold register.
- valid_o = resp_valid && state==RUN; pc_o = resp_pc; halted_o = (state==HALTED).
- Priority per edge: rst > redirect_i > halt detect > stall_i > advance.
- Redirect (any state): fetch_pc<=redirect_addr_i, resp_valid<=0, state<=RUN. Redirect in cycle t gives valid_o=0 in t+1, with mem[target] valid and pc_o=target in t+2. The in-flight word is squashed.
- Halt detect (RUN, HALT_EN=1): if valid_o && !stall_i && instr_o==HALT_WORD, the halt word is consumed by decode that cycle. Then: state<=HALTED, resp_valid<=0, fetch_pc held. In HALTED, stall_i is ignored, registers are frozen, valid_o=0, and only redirect or rst exits.
- Stall (RUN, no redirect): all registers hold. valid_o, pc_o and instr_o remain unchanged for the whole stall, including a stall on the cycle right after reset or redirect (valid_o=0 is held).
- Advance (RUN, !stall, no redirect, no halt): resp_pc<=fetch_pc, resp_valid<=1, fetch_pc<=fetch_pc+1. This gives one instruction per cycle in steady state.
- Arithmetic: fetch_pc increment is modulo 2^ADDR_W (8191 wraps to 0, no flag). redirect_addr_i is used unmodified.
- No combinational path from imem_data_i to imem_addr_o. The only combinational path into imem_addr_o is from stall_i.

Test Plan:
- Reset: preload mem[k]=k+0x100 and hold rst 2 cycles, then release -> cycle 1 valid_o=0, imem_addr_o=0; cycle 2 valid_o=1, pc_o=0, instr_o=0x100; pc_o then 1, 2, 3 with instr_o 0x101, 0x102, 0x103 on consecutive cycles.
- Stall: assert stall_i for 3 cycles while pc_o=5 -> pc_o=5, instr_o=0x105 and valid_o=1 held all 3 cycles, imem_addr_o=5 during stall; after release pc_o=6 next cycle, with no skipped or duplicated PC.
- Redirect: pulse redirect_i with addr 0x40 while pc_o=7 -> next cycle valid_o=0; following cycle pc_o=0x40, instr_o=0x140; stall_i asserted with redirect_i has no effect on the redirect.
- Halt: mem[3]=0xFFFF_FFFF -> pc_o=3 valid once, then halted_o=1, valid_o=0 indefinitely even with stall toggling; redirect to 0 -> halted_o=0, pc_o=0 valid two cycles later.
- Wrap: redirect to 8190 -> pc_o sequence 8190, 8191, 0, 1 with matching mem data.
- Reset mid-stall and in HALTED: assert rst -> next cycle valid_o=0, halted_o=0, imem_addr_o=RESET_PC; normal fetch resumes.
